// File: rtl/cache_arbiter_pkg.sv
// rtl/cache_arbiter_pkg.sv - shared types for the cache memory-port arbiter
package arbiter_types;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    COOL
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_grant_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// rtl/cache_arbiter_if.sv - cache-side and memory-side bus bundle for the arbiter
interface cache_arbiter_if #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
);

  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;

  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  // Arbiter view: requests and memory completions come in, strobes and fills go out.
  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
  );

  // Environment view: the two caches plus the memory model.
  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
  );

endinterface

// File: rtl/cache_arbiter_pick.sv
// rtl/cache_arbiter_pick.sv - combinational requester picker for the arbiter
module arb_pick
  import arbiter_types::*;
#(
  parameter bit RR_FAIR = 1'b1
) (
  input  logic       i_req,
  input  logic       d_req,
  input  arb_grant_t last_grant,
  output logic       grant_valid,
  output arb_grant_t grant
);

  // Lone requester always wins; on contention either alternate or favour the D-cache.
  always_comb begin
    grant_valid = i_req | d_req;
    grant       = GRANT_D;
    if (i_req && d_req) begin
      if (RR_FAIR) begin
        grant = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
      end
    end else if (i_req) begin
      grant = GRANT_I;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - shares one memory port between I-cache and D-cache
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter bit RR_FAIR    = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  cache_arbiter_if.slave  bus
);

  arb_state_t            state_q;
  arb_state_t            state_d;
  arb_grant_t            last_grant_q;
  arb_grant_t            grant;
  logic                  grant_valid;
  logic                  d_req;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  write_q;
  logic                  mem_read_c;
  logic                  mem_write_c;
  logic                  i_resp_c;
  logic                  d_resp_c;

  // A D-cache read and write together is illegal upstream; the write wins.
  assign d_req = bus.d_read | bus.d_write;

  arb_pick #(.RR_FAIR(RR_FAIR)) u_pick (
    .i_req       (bus.i_read),
    .d_req       (d_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the granted request and remember who was served last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= GRANT_D;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
    end else begin
      if (state_q == IDLE && grant_valid) begin
        if (grant == GRANT_I) begin
          addr_q  <= bus.i_address;
          write_q <= 1'b0;
        end else begin
          addr_q  <= bus.d_address;
          wdata_q <= bus.d_wdata;
          write_q <= bus.d_write;
        end
      end
      if (bus.mem_resp && (state_q == SERVE_I || state_q == SERVE_D)) begin
        last_grant_q <= (state_q == SERVE_I) ? GRANT_I : GRANT_D;
      end
    end
  end

  // Next state plus strobes and responses; mem_resp only counts while serving.
  always_comb begin
    state_d     = state_q;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    i_resp_c    = 1'b0;
    d_resp_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = (grant == GRANT_I) ? SERVE_I : SERVE_D;
        end
      end
      SERVE_I: begin
        mem_read_c  = ~write_q;
        mem_write_c = write_q;
        if (bus.mem_resp) begin
          i_resp_c = 1'b1;
          state_d  = COOL;
        end
      end
      SERVE_D: begin
        mem_read_c  = ~write_q;
        mem_write_c = write_q;
        if (bus.mem_resp) begin
          d_resp_c = 1'b1;
          state_d  = COOL;
        end
      end
      COOL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_read    = mem_read_c;
  assign bus.mem_write   = mem_write_c;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.i_resp      = i_resp_c;
  assign bus.d_resp      = d_resp_c;
  // Fill data goes to both caches; only the matching resp qualifies it.
  assign bus.i_rdata     = bus.mem_rdata;
  assign bus.d_rdata     = bus.mem_rdata;

  // Upstream protocol checks: no simultaneous D read/write, requests held while served.
  a_d_rw_excl : assert property (@(posedge clk) disable iff (!rst)
    !(bus.d_read && bus.d_write));
  a_i_held : assert property (@(posedge clk) disable iff (!rst)
    (state_q == SERVE_I) |-> bus.i_read);
  a_d_held : assert property (@(posedge clk) disable iff (!rst)
    (state_q == SERVE_D) |-> d_req);

endmodule
